// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin arbiter for the register file write port
//
// Purpose: shares the register file's single write port and its row-enable
// decode between requester A (ALU path) and requester B (mult/div or load
// path). Grants are combinational; the winner's address/data/source are
// registered and a one-cycle one-hot row enable is issued on the next edge.
//
// Optional feature macro: REGWR_STALL_CNT_EN adds a saturating 16-bit
// stall_count output (cycles in which a valid requester was not granted).
//
// Ports:
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   wr_stall              register file busy, suppresses all grants
//   a_valid/a_addr/a_data requester A write request, a_ready = accepted
//   b_valid/b_addr/b_data requester B write request, b_ready = accepted
//   wr_en_onehot          registered one-hot row enable (one cycle per write)
//   wr_addr/wr_data       registered address/data of the last issued write
//   wr_src                0 = last write came from A, 1 = from B
//   stall_count           (REGWR_STALL_CNT_EN only) saturating wait counter

module regfile_write_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 5,
    parameter int ZERO_REG_PROTECT = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         wr_stall,
    input  logic                         a_valid,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [DATA_WIDTH-1:0]        a_data,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_WIDTH-1:0]        b_data,
    output logic                         b_ready,
    output logic [(2**ADDR_WIDTH)-1:0]   wr_en_onehot,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
`ifdef REGWR_STALL_CNT_EN
    output logic                         wr_src,
    output logic [15:0]                  stall_count
`else
    output logic                         wr_src
`endif
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [NUM_REGS-1:0] ONE_HOT_LSB = NUM_REGS'(1);

    logic                  prio_q, prio_d;
    logic [NUM_REGS-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_src_q, wr_src_d;

    logic                  grant_a, grant_b;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // prio_q: 0 favours A, 1 favours B; a lone requester always wins.
    assign grant_a = !wr_stall && a_valid && (!b_valid || !prio_q);
    assign grant_b = !wr_stall && b_valid && (!a_valid ||  prio_q);
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign sel_addr = grant_b ? b_addr : a_addr;
    assign sel_data = grant_b ? b_data : a_data;

    always_comb begin
        prio_d    = prio_q;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (grant_a || grant_b) begin
            // Pointer flips to the other requester after every grant.
            prio_d    = grant_a;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            wr_src_d  = grant_b;
            // A protected register 0 still completes the transfer but
            // never raises its row enable.
            if (!((ZERO_REG_PROTECT != 0) && (sel_addr == '0))) begin
                wr_en_d = ONE_HOT_LSB << sel_addr;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q    <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign wr_en_onehot = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_src       = wr_src_q;

`ifdef REGWR_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        waiting;

    assign waiting = (a_valid && !grant_a) || (b_valid && !grant_b);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (waiting && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench for regfile_write_arbiter

module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr_stall;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [31:0] wr_en_onehot;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_src;

    logic        np_a_ready, np_b_ready;
    logic [31:0] np_wr_en_onehot;
    logic [4:0]  np_wr_addr;
    logic [31:0] np_wr_data;
    logic        np_wr_src;
`ifdef REGWR_STALL_CNT_EN
    logic [15:0] stall_count, np_stall_count;
`endif

    always #5 clock = ~clock;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_PROTECT(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .wr_stall(wr_stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .wr_en_onehot(wr_en_onehot), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef REGWR_STALL_CNT_EN
        .wr_src(wr_src), .stall_count(stall_count)
`else
        .wr_src(wr_src)
`endif
    );

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_PROTECT(0)) u_dut_np (
        .clock(clock), .reset_n(reset_n), .wr_stall(wr_stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(np_a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(np_b_ready),
        .wr_en_onehot(np_wr_en_onehot), .wr_addr(np_wr_addr), .wr_data(np_wr_data),
`ifdef REGWR_STALL_CNT_EN
        .wr_src(np_wr_src), .stall_count(np_stall_count)
`else
        .wr_src(np_wr_src)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_prio;
    logic [31:0] m_en, m_en_np, m_data;
    logic [4:0]  m_addr;
    logic        m_src;
    int          m_stall_cnt;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf [32];
    logic        last_ga, last_gb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0; m_en = 0; m_en_np = 0; m_addr = 0; m_data = 0; m_src = 0;
        m_stall_cnt = 0;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic st);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        wr_stall = st;
    endtask

    task automatic check_outputs();
        chk("wr_en", wr_en_onehot, m_en);
        chk("wr_en_np", np_wr_en_onehot, m_en_np);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("wr_src", wr_src, m_src);
`ifdef REGWR_STALL_CNT_EN
        chk("stall_count", stall_count, m_stall_cnt);
`endif
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic ga, gb;
        logic [4:0]  sa;
        logic [31:0] sd;
        #1;
        ga = !wr_stall && a_valid && (!b_valid || m_prio == 0);
        gb = !wr_stall && b_valid && (!a_valid || m_prio == 1);
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("np_ready", {np_a_ready, np_b_ready}, {ga, gb});
        sa = ga ? a_addr : b_addr;
        sd = ga ? a_data : b_data;
        last_ga = ga; last_gb = gb;
        @(posedge clock);
        if (ga || gb) begin
            m_addr  = sa;
            m_data  = sd;
            m_src   = gb;
            m_en_np = 32'h1 << sa;
            m_en    = (sa == 0) ? 32'h0 : m_en_np;
            m_prio  = ga ? 1 : 0;
            if (sa != 0) model_rf[sa] = sd;
        end else begin
            m_en = 0; m_en_np = 0;
        end
        if (((a_valid && !ga) || (b_valid && !gb)) && m_stall_cnt < 65535) m_stall_cnt++;
        @(negedge clock);
        check_outputs();
        for (int i = 0; i < 32; i++) if (wr_en_onehot[i]) dut_rf[i] = wr_data;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 32; i++) begin model_rf[i] = 0; dut_rf[i] = 0; end
        #2;
        chk("reset_en", wr_en_onehot, 32'h0);
        chk("reset_addr", wr_addr, 5'h0);
        chk("reset_data", wr_data, 32'h0);
        do_reset();

        // single A write
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step();
        chk("single_ready", last_ga, 1'b1);
        chk("single_en", wr_en_onehot, 32'h00000020);
        chk("single_data", wr_data, 32'hDEADBEEF);
        chk("single_src", wr_src, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("single_en_off", wr_en_onehot, 32'h0);

        // asynchronous reset in the middle of a pulse
        drive(1, 5, 32'h12345678, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_en", wr_en_onehot, 32'h0);
        chk("async_addr", wr_addr, 5'h0);
        chk("async_data", wr_data, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // contention from reset: A then B
        do_reset();
        drive(1, 3, 32'hA3, 1, 7, 32'hB7, 0);
        step();
        chk("cont_en1", wr_en_onehot, 32'h8);
        drive(0, 0, 0, 1, 7, 32'hB7, 0);
        step();
        chk("cont_en2", wr_en_onehot, 32'h80);
        chk("cont_src2", wr_src, 1'b1);

        // zero register via B
        do_reset();
        drive(0, 0, 0, 1, 0, 32'h55, 0);
        step();
        chk("zero_ready", last_gb, 1'b1);
        chk("zero_en", wr_en_onehot, 32'h0);
        chk("zero_en_np", np_wr_en_onehot, 32'h1);
        chk("zero_src", wr_src, 1'b1);
        chk("zero_addr", wr_addr, 5'h0);

        // stall for 3 cycles, then A first
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, 32'h44, 1, 6, 32'h66, 1);
            step();
            chk("stall_en", wr_en_onehot, 32'h0);
        end
`ifdef REGWR_STALL_CNT_EN
        chk("stall_cnt3", stall_count, 16'd3);
`endif
        drive(1, 4, 32'h44, 1, 6, 32'h66, 0);
        step();
        chk("stall_a_first", last_ga, 1'b1);
        drive(0, 0, 0, 1, 6, 32'h66, 0);
        step();

        // same address from both requesters
        do_reset();
        drive(1, 9, 32'h1, 1, 9, 32'h2, 0);
        step();
        chk("same_en1", wr_en_onehot, 32'h200);
        drive(0, 0, 0, 1, 9, 32'h2, 0);
        step();
        chk("same_en2", wr_en_onehot, 32'h200);
        chk("same_data", wr_data, 32'h2);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // randomized traffic, requesters hold until accepted
        begin
            logic av, bv, st;
            logic [4:0] aa, ba;
            logic [31:0] ad, bd;
            av = 0; bv = 0; aa = 0; ba = 0; ad = 0; bd = 0;
            for (int n = 0; n < 600; n++) begin
                if (!av || last_ga) begin
                    av = ($urandom_range(0, 99) < 60);
                    aa = 5'($urandom_range(0, 31));
                    ad = $urandom;
                end
                if (!bv || last_gb) begin
                    bv = ($urandom_range(0, 99) < 60);
                    ba = 5'($urandom_range(0, 31));
                    bd = $urandom;
                end
                st = ($urandom_range(0, 99) < 20);
                last_ga = 0; last_gb = 0;
                drive(av, aa, ad, bv, ba, bd, st);
                step();
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), dut_rf[i], model_rf[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
